// File: rtl/trailing_zeroes_stream.sv
// trailing_zeroes_stream
// Counts trailing zeros (mode 0) or trailing ones (mode 1) across a multi-beat
// operand streamed least-significant word first. Valid/ready on both sides,
// registered result. A packet ends on din_last or is force-closed after
// MAX_BEATS beats, in which case dout_trunc flags the early termination.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no packet open; next accepted beat is beat 1 and latches mode
// ACCUM  | packet open; accumulating or frozen once a terminating bit seen
module trailing_zeroes_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 4,
    localparam int CW = $clog2(DATA_WIDTH * MAX_BEATS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  din_last,
    input  logic                  mode,
    output logic                  din_ready,
    output logic [CW-1:0]         dout,
    output logic                  dout_found,
    output logic                  dout_trunc,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    // Beat counter must hold values 0..MAX_BEATS.
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic            found_q, found_d;
    logic [CW-1:0]   dout_q, dout_d;
    logic            dout_found_q, dout_found_d;
    logic            dout_trunc_q, dout_trunc_d;
    logic            dout_valid_q, dout_valid_d;

    logic            accept;
    logic            tgt;
    logic [CW-1:0]   beat_run;
    logic            beat_full;
    logic [BW-1:0]   cur_idx;
    logic            term;

    // Per-beat run length of the target bit, starting from bit 0.
    always_comb begin
        logic run;
        tgt      = (state_q == S_IDLE) ? mode : mode_q;
        beat_run = '0;
        run      = 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (run && (din[i] == tgt)) begin
                beat_run = beat_run + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        beat_full = (beat_run == CW'(DATA_WIDTH));
    end

    // Beat index of the beat being offered and whether it closes the packet.
    // beat_cnt_q is 0 whenever no packet is open, so the first beat is index 1.
    always_comb begin
        cur_idx = beat_cnt_q + BW'(1);
        term    = din_last | (cur_idx == BW'(MAX_BEATS));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: open on a non-terminating accept, close on a terminating one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !term) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && term) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake and registered result.
    always_comb begin
        din_ready  = ~dout_valid_q | dout_ready;
        accept     = din_valid & din_ready;
        dout       = dout_q;
        dout_found = dout_found_q;
        dout_trunc = dout_trunc_q;
        dout_valid = dout_valid_q;
    end

    // Datapath next values: accumulation, freeze-on-found and result hand-off.
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        found_d      = found_q;
        dout_d       = dout_q;
        dout_found_d = dout_found_q;
        dout_trunc_d = dout_trunc_q;
        dout_valid_d = dout_valid_q;

        if (dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (accept) begin
            if (state_q == S_IDLE) begin
                // First beat always loads, regardless of the previous packet's found flag.
                mode_d  = mode;
                acc_d   = beat_run;
                found_d = ~beat_full;
            end else if (!found_q) begin
                acc_d   = acc_q + beat_run;
                found_d = ~beat_full;
            end

            if (term) begin
                beat_cnt_d   = '0;
                dout_d       = acc_d;
                dout_found_d = found_d;
                dout_trunc_d = ~din_last;
                dout_valid_d = 1'b1;
            end else begin
                beat_cnt_d   = cur_idx;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q   <= '0;
            mode_q       <= 1'b0;
            acc_q        <= '0;
            found_q      <= 1'b0;
            dout_q       <= '0;
            dout_found_q <= 1'b0;
            dout_trunc_q <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            found_q      <= found_d;
            dout_q       <= dout_d;
            dout_found_q <= dout_found_d;
            dout_trunc_q <= dout_trunc_d;
            dout_valid_q <= dout_valid_d;
        end
    end

endmodule

// File: tb/tb_trailing_zeroes_stream.sv
// Bench for trailing_zeroes_stream (DATA_WIDTH=8, MAX_BEATS=4).
// Expected results come from a packet-level model: beats are grouped into
// operands (closed by last or by the 4th beat), concatenated into one wide
// integer and the trailing target bits counted with plain arithmetic.
module tb_trailing_zeroes_stream;

    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = $clog2(DW * MB) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_last = 1'b0;
    logic          mode = 1'b0;
    logic          din_ready;
    logic [CW-1:0] dout;
    logic          dout_found;
    logic          dout_trunc;
    logic          dout_valid;
    logic          dout_ready = 1'b1;

    trailing_zeroes_stream #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .mode       (mode),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_found (dout_found),
        .dout_trunc (dout_trunc),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            l;
        bit            m;
    } beat_t;

    typedef struct {
        int cnt;
        bit found;
        bit trunc;
    } result_t;

    beat_t         beats[$];
    result_t       exp_q[$];
    logic [DW-1:0] grp[$];
    bit            grp_mode;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    endtask

    // Model: close the current operand and queue its expected result.
    function automatic void close_grp(input bit trunc);
        longint  op = 0;
        int      total = grp.size() * DW;
        int      n = 0;
        result_t r;
        for (int j = 0; j < grp.size(); j++) op |= longint'(grp[j]) << (DW * j);
        if (grp_mode) op = ~op;
        while (n < total && ((op >> n) & 1) == 0) n++;
        r.cnt   = n;
        r.found = (n < total);
        r.trunc = trunc;
        exp_q.push_back(r);
        grp.delete();
    endfunction

    function automatic void add_beat(input logic [DW-1:0] d, input bit l, input bit m);
        beat_t b;
        b.d = d; b.l = l; b.m = m;
        beats.push_back(b);
        if (grp.size() == 0) grp_mode = m;
        grp.push_back(d);
        if (l) close_grp(1'b0);
        else if (grp.size() == MB) close_grp(1'b1);
    endfunction

    // Drive the queued beats, checking every result that transfers.
    task automatic run_stream(input int budget, input bit rnd);
        int            idx = 0;
        int            cyc = 0;
        bit            held = 0;
        bit            stall = 0;
        logic [CW-1:0] sd = '0;
        result_t       e;
        while ((idx < beats.size() || exp_q.size() > 0) && cyc < budget) begin
            if (idx < beats.size()) begin
                din       = beats[idx].d;
                din_last  = beats[idx].l;
                mode      = beats[idx].m;
                din_valid = held ? 1'b1 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
            end else begin
                din_valid = 1'b0;
            end
            dout_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            @(negedge clk);
            if (stall) begin
                check("hold_dout", dout, sd);
                check("hold_valid", dout_valid, 1);
            end
            check("din_ready", din_ready, (!dout_valid || dout_ready));
            stall = dout_valid && !dout_ready;
            sd    = dout;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", dout_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e.cnt);
                    check("dout_found", dout_found, e.found);
                    check("dout_trunc", dout_trunc, e.trunc);
                end
            end
            if (din_valid && din_ready) begin
                idx++;
                held = 0;
            end else begin
                held = din_valid;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_complete", (idx == beats.size() && exp_q.size() == 0), 1);
        beats.delete();
        exp_q.delete();
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offer one beat and wait (bounded) until it is accepted.
    task automatic put(input logic [DW-1:0] d, input bit l, input bit m);
        bit ok = 0;
        din = d; din_last = l; mode = m; din_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (din_ready) ok = 1;
            else @(posedge clk);
        end
        if (!ok) check("put_accept", din_ready, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_found", dout_found, 0);
        check("rst_trunc", dout_trunc, 0);
        check("rst_valid", dout_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_din_ready", din_ready, 1);
        @(posedge clk); #1;

        // Single beats, multi-beat, all-zero full length, truncation, mode 1
        add_beat(8'h28, 1, 0);
        add_beat(8'h00, 1, 0);
        add_beat(8'h00, 0, 0); add_beat(8'h00, 0, 0); add_beat(8'h10, 1, 0);
        add_beat(8'h01, 0, 0); add_beat(8'h00, 1, 0);
        for (int i = 0; i < 4; i++) add_beat(8'h00, (i == 3), 0);
        for (int i = 0; i < 5; i++) add_beat(8'h00, (i == 4), 0);
        add_beat(8'hFF, 0, 1); add_beat(8'h07, 1, 0);
        add_beat(8'hFF, 0, 1); add_beat(8'hFF, 0, 1); add_beat(8'hFF, 0, 0); add_beat(8'hFF, 1, 0);
        run_stream(200, 0);

        // Randomised packets, random gaps and backpressure
        for (int p = 0; p < 60; p++) begin
            int len = $urandom_range(6, 1);
            bit pm  = $urandom_range(1);
            for (int b = 0; b < len; b++) begin
                logic [DW-1:0] d;
                case ($urandom_range(3))
                    0, 1:    d = pm ? 8'hFF : 8'h00;
                    2:       d = DW'(1) << $urandom_range(DW - 1);
                    default: d = DW'($urandom);
                endcase
                if (pm && $urandom_range(3) == 2) d = ~d;
                add_beat(d, (b == len - 1), (b == 0) ? pm : bit'($urandom_range(1)));
            end
        end
        run_stream(4000, 1);

        // Backpressure: stalled result blocks input, then pops with same-cycle accept
        dout_ready = 1'b0;
        put(8'h28, 1, 0);
        check("bp_first", dout, 3);
        din = 8'h80; din_last = 1'b1; mode = 1'b0; din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_din_ready", din_ready, 0);
            check("bp_dout_stable", dout, 3);
            check("bp_valid_stable", dout_valid, 1);
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", din_ready, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        check("bp_next_dout", dout, 7);
        check("bp_next_valid", dout_valid, 1);
        check("bp_next_found", dout_found, 1);
        @(posedge clk); #1;
        check("bp_drained", dout_valid, 0);

        // Reset drops a pending result
        dout_ready = 1'b0;
        put(8'h28, 1, 0);
        check("rp_pending", dout_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rp_valid_cleared", dout_valid, 0);
        check("rp_dout_cleared", dout, 0);
        reset = 1'b0;
        dout_ready = 1'b1;

        // Reset mid-packet discards the partial accumulation
        put(8'h00, 0, 0);
        put(8'h00, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rm_dout", dout, 0);
        check("rm_found", dout_found, 0);
        check("rm_trunc", dout_trunc, 0);
        check("rm_valid", dout_valid, 0);
        reset = 1'b0;
        put(8'h04, 1, 0);
        check("rm_result", dout, 2);
        check("rm_result_found", dout_found, 1);
        check("rm_result_valid", dout_valid, 1);
        check("rm_result_trunc", dout_trunc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
